// File: rtl/buffer_if_id.sv
// buffer_if_id: two-entry elastic IF/ID pipeline register with flush
// Ports:
//   clk_ifid, rst_n_ifid           clock, asynchronous active-low reset
//   in_valid/in_ready              fetch-side handshake
//   in_instruction, in_pc_plus4    fetched instruction and its PC+4
//   out_valid/out_ready            decode-side handshake
//   out_instruction, out_pc_plus4  head entry, NOP_INSTR/0 when empty
//   flush                          taken branch, discards every entry
//   occupancy                      valid entries (0..2)
//   flush_cnt                      saturating count of flushes that dropped something
module buffer_if_id #(
    parameter int                DATA_W    = 32,
    parameter logic [DATA_W-1:0] NOP_INSTR = '0,
    parameter int                CNT_W     = 8
) (
    input  logic              clk_ifid,
    input  logic              rst_n_ifid,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_instruction,
    input  logic [DATA_W-1:0] in_pc_plus4,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_instruction,
    output logic [DATA_W-1:0] out_pc_plus4,
    input  logic              flush,
    output logic [1:0]        occupancy,
    output logic [CNT_W-1:0]  flush_cnt
);
    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;
    logic [1:0]          state_q, state_d;
    logic [2*DATA_W-1:0] h_q, h_d, s_q, s_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic                in_fire, out_fire;
    logic [2*DATA_W-1:0] in_entry;
    assign in_ready        = state_q != FULL;
    assign out_valid       = state_q != EMPTY;
    assign in_fire         = in_valid & in_ready;
    assign out_fire        = out_valid & out_ready;
    assign in_entry        = {in_instruction, in_pc_plus4};
    assign occupancy       = state_q;
    assign flush_cnt       = cnt_q;
    assign out_instruction = out_valid ? h_q[2*DATA_W-1:DATA_W] : NOP_INSTR;
    assign out_pc_plus4    = out_valid ? h_q[DATA_W-1:0] : '0;
    always_comb begin
        state_d = state_q;
        h_d     = h_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        if (flush) begin
            state_d = EMPTY;
            // only count flushes that actually threw an instruction away
            if ((out_valid || in_fire) && cnt_q != '1)
                cnt_d = cnt_q + CNT_W'(1);
        end else if (state_q == EMPTY) begin
            if (in_fire) begin
                h_d     = in_entry;
                state_d = ONE;
            end
        end else if (state_q == ONE) begin
            if (in_fire && out_fire) begin
                h_d = in_entry;
            end else if (in_fire) begin
                s_d     = in_entry;
                state_d = FULL;
            end else if (out_fire) begin
                state_d = EMPTY;
            end
        end else if (out_fire) begin
            h_d     = s_q;
            state_d = ONE;
        end
    end
    always_ff @(posedge clk_ifid or negedge rst_n_ifid) begin
        if (!rst_n_ifid) begin
            state_q <= EMPTY;
            h_q     <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            h_q     <= h_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
        end
    end
endmodule

// File: tb/tb_buffer_if_id.sv
// tb_buffer_if_id: table-driven and scoreboard checks for buffer_if_id
module tb_buffer_if_id;
    localparam int DATA_W = 32;
    localparam int CNT_W  = 8;
    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b0, flush = 1'b0;
    logic [DATA_W-1:0] in_instruction = '0, in_pc_plus4 = '0, out_instruction, out_pc_plus4;
    logic [1:0]        occupancy;
    logic [CNT_W-1:0]  flush_cnt;
    buffer_if_id #(.DATA_W(DATA_W), .NOP_INSTR(32'h0), .CNT_W(CNT_W)) dut (
        .clk_ifid(clk), .rst_n_ifid(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_instruction(in_instruction), .in_pc_plus4(in_pc_plus4),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_instruction(out_instruction), .out_pc_plus4(out_pc_plus4),
        .flush(flush), .occupancy(occupancy), .flush_cnt(flush_cnt)
    );
    always #5 clk = ~clk;
    typedef struct {
        logic        iv;
        logic [31:0] instr;
        logic [31:0] pc;
        logic        ordy;
        logic        fl;
        int          exp_occ;
        int          exp_cnt;
    } vec_t;
    vec_t        vecs[16];
    logic [63:0] sb[$];
    int          m_cnt = 0;
    int          n_vec = 0;
    int          n_err = 0;
    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    task automatic check_outputs();
        chk("out_valid", 32'(out_valid), 32'(sb.size() != 0));
        chk("in_ready", 32'(in_ready), 32'(sb.size() < 2));
        chk("occupancy", 32'(occupancy), 32'(sb.size()));
        chk("out_instruction", out_instruction, sb.size() != 0 ? sb[0][63:32] : 32'h0);
        chk("out_pc_plus4", out_pc_plus4, sb.size() != 0 ? sb[0][31:0] : 32'h0);
        chk("flush_cnt", 32'(flush_cnt), 32'(m_cnt));
    endtask
    // one cycle: drive at negedge, check against scoreboard, advance scoreboard, clock
    task automatic step(input logic iv, input logic [31:0] instr, input logic [31:0] pc,
                        input logic ordy, input logic fl, input int exp_occ, input int exp_cnt);
        bit fire_in, fire_out;
        in_valid = iv; in_instruction = instr; in_pc_plus4 = pc; out_ready = ordy; flush = fl;
        #1;
        check_outputs();
        fire_in  = iv && sb.size() < 2;
        fire_out = ordy && sb.size() != 0;
        if (fl) begin
            if ((sb.size() != 0 || fire_in) && m_cnt < (1 << CNT_W) - 1) m_cnt++;
            sb.delete();
        end else begin
            if (fire_out) void'(sb.pop_front());
            if (fire_in) sb.push_back({instr, pc});
        end
        @(posedge clk);
        @(negedge clk);
        if (exp_occ >= 0) chk("table_occupancy", 32'(occupancy), 32'(exp_occ));
        if (exp_cnt >= 0) chk("table_flush_cnt", 32'(flush_cnt), 32'(exp_cnt));
    endtask
    initial begin
        vecs[0]  = '{1, 32'h20080005, 32'd4,  1, 0, 1, 0};
        vecs[1]  = '{1, 32'h21290001, 32'd8,  1, 0, 1, 0};
        vecs[2]  = '{1, 32'h01095020, 32'd12, 1, 0, 1, 0};
        vecs[3]  = '{0, 32'h0,        32'd0,  1, 0, 0, 0};
        vecs[4]  = '{1, 32'h8C010000, 32'd16, 0, 0, 1, 0};
        vecs[5]  = '{1, 32'h8C020004, 32'd20, 0, 0, 2, 0};
        vecs[6]  = '{1, 32'hDEADBEEF, 32'd24, 0, 0, 2, 0};
        vecs[7]  = '{0, 32'h0,        32'd0,  1, 0, 1, 0};
        vecs[8]  = '{0, 32'h0,        32'd0,  1, 0, 0, 0};
        vecs[9]  = '{1, 32'hAAAA0001, 32'd28, 0, 0, 1, 0};
        vecs[10] = '{1, 32'hAAAA0002, 32'd32, 0, 0, 2, 0};
        vecs[11] = '{1, 32'h10220003, 32'd36, 0, 1, 0, 1};
        vecs[12] = '{0, 32'h0,        32'd0,  1, 0, 0, 1};
        vecs[13] = '{0, 32'h0,        32'd0,  0, 1, 0, 1};
        vecs[14] = '{1, 32'h11110000, 32'd40, 1, 0, 1, 1};
        vecs[15] = '{1, 32'h22220000, 32'd44, 1, 1, 0, 2};
        // reset is visible without any clock edge
        #2;
        chk("reset_out_valid", 32'(out_valid), 32'h0);
        chk("reset_in_ready", 32'(in_ready), 32'h1);
        chk("reset_occupancy", 32'(occupancy), 32'h0);
        chk("reset_out_instruction", out_instruction, 32'h0);
        chk("reset_flush_cnt", 32'(flush_cnt), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++)
            step(vecs[i].iv, vecs[i].instr, vecs[i].pc, vecs[i].ordy, vecs[i].fl,
                 vecs[i].exp_occ, vecs[i].exp_cnt);
        // flushes that drop an incoming instruction, enough to saturate the counter
        for (int i = 0; i < (1 << CNT_W) + 3; i++)
            step(1, 32'hF0000000 + 32'(i), 32'(i * 4), 0, 1, 0, -1);
        chk("flush_cnt_saturated", 32'(flush_cnt), 32'hFF);
        step(0, 32'h0, 32'h0, 1, 1, 0, 255);
        // fill to FULL, then reset between clock edges
        step(1, 32'h33330000, 32'd48, 0, 0, 1, 255);
        step(1, 32'h44440000, 32'd52, 0, 0, 2, 255);
        #2;
        rst_n = 1'b0;
        #1;
        chk("async_out_valid", 32'(out_valid), 32'h0);
        chk("async_occupancy", 32'(occupancy), 32'h0);
        chk("async_in_ready", 32'(in_ready), 32'h1);
        chk("async_out_instruction", out_instruction, 32'h0);
        chk("async_flush_cnt", 32'(flush_cnt), 32'h0);
        sb.delete();
        m_cnt = 0;
        @(negedge clk);
        rst_n = 1'b1;
        step(1, 32'h55550000, 32'd56, 1, 0, 1, 0);
        step(1, 32'h66660000, 32'd60, 0, 0, 2, 0);
        step(0, 32'h0, 32'h0, 1, 0, 1, 0);
        step(0, 32'h0, 32'h0, 1, 0, 0, 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/buffer_if_id.md
Name: buffer_if_id

Overview:
Two-entry elastic pipeline register between the fetch stage (instruction memory + PC logic) and the decode/execute stage (register file, control, sign-extension, branch-equal generation).
- Decouples fetch from decode with a valid/ready handshake.
- Preserves instruction order.
- Drops all in-flight instructions when a taken branch is signalled.
- Presents a NOP to decode whenever it holds no valid entry.

Parameters:
DATA_W, 32, width of instruction and PC+4 fields
NOP_INSTR, 32'h00000000, instruction word driven on out_instruction when out_valid=0
CNT_W, 8, width of the saturating flush counter

Ports:
clk_ifid  input  1  clock; all state updates on rising edge
rst_n_ifid  input  1  asynchronous active-low reset
in_valid  input  1  fetch presents a valid instruction
in_ready  output  1  buffer can accept an instruction this cycle
in_instruction  input  DATA_W  fetched instruction word
in_pc_plus4  input  DATA_W  PC+4 of the fetched instruction
out_valid  output  1  decode-side entry valid
out_ready  input  1  decode consumes the head entry this cycle
out_instruction  output  DATA_W  head instruction, or NOP_INSTR when out_valid=0
out_pc_plus4  output  DATA_W  head PC+4, or 0 when out_valid=0
flush  input  1  taken branch (branch-equal resolved true); discard everything
occupancy  output  2  number of valid entries (0..2)
flush_cnt  output  CNT_W  count of flushes that discarded at least one entry; saturating

Behaviour:
- Reset (async, rst_n_ifid=0):
  - State EMPTY.
  - out_valid=0, out_instruction=NOP_INSTR, out_pc_plus4=0, occupancy=0, flush_cnt=0, in_ready=1.
  - Takes effect immediately, not at the next edge.
  - Reset mid-operation discards both entries with no completion of a pending transfer.
- Storage: head register (H) and skid register (S), each holding {instruction, pc_plus4}.
- Handshakes: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
- in_ready = (state != FULL). It is a function of registered state only, with no combinational path from out_ready.
- out_valid = (state != EMPTY). out_* are driven from H.
- States and transitions (flush=0):
  - EMPTY: in_fire -> H<=in, go ONE.
  - ONE, neither fire: hold.
  - ONE, in_fire only: S<=in, go FULL.
  - ONE, out_fire only: go EMPTY.
  - ONE, both fire: H<=in, stay ONE (zero-bubble streaming, one instruction per cycle).
  - FULL, out_fire: H<=S, go ONE. in_fire is impossible because in_ready=0.
  - FULL, no out_fire: hold.
- Latency: an instruction accepted at edge N appears on out_* after edge N (one cycle), provided the buffer was EMPTY or draining.
- Ordering: strict FIFO; S never bypasses H.
- Flush (priority over all other events):
  - Next state EMPTY; H and S invalidated.
  - An in_fire in the same cycle is discarded.
  - An out_fire in the same cycle still counts as consumed by decode; the entry is simply not retained.
  - flush_cnt increments by 1 when flush=1 and occupancy>0, or when flush=1 and in_fire=1 (some entry was actually dropped).
  - flush_cnt saturates at all-ones and never wraps.
- Data fields of invalid entries are don't-care internally. The outputs must show NOP_INSTR/0 when out_valid=0.
- occupancy encoding: EMPTY=0, ONE=1, FULL=2. The value 3 never occurs.
- Stable output rule: while out_valid=1 and out_ready=0, out_instruction and out_pc_plus4 hold constant until out_fire or flush.

Test Plan:
1. Reset then stream: release rst_n_ifid, in_valid=1 with instr 0x20080005/0x21290001/0x01095020 (pc+4=4,8,12), out_ready=1 -> out_valid rises one cycle after each accept, outputs in order, occupancy stays 1, in_ready stays 1.
2. Backpressure: out_ready=0 while feeding 0x8C010000 then 0x8C020004 -> occupancy 1 then 2, in_ready=0 at FULL, out_instruction held at 0x8C010000; raise out_ready -> 0x8C010000 then 0x8C020004 delivered, in_ready=1 after the first drain.
3. Flush at FULL: occupancy=2, assert flush with in_valid=1 (0x10220003) -> next cycle occupancy=0, out_valid=0, out_instruction=0x00000000, flush_cnt=1, 0x10220003 never appears at the output.
4. Flush when empty with in_valid=0 -> occupancy stays 0, flush_cnt unchanged; repeat flush with data 2^CNT_W+3 times -> flush_cnt saturates at 0xFF.
5. Async reset mid-stream: occupancy=2, drop rst_n_ifid between clock edges -> out_valid=0 and occupancy=0 immediately, before the next edge; stream resumes correctly after release.
